// File: rtl/pipe_shifter_pkg.sv
// Shared op encodings and shift-amount grouping helpers for the pipelined shifter.
// Latency: n/a (constants and elaboration-time functions only).
// Backpressure: n/a.
package pipe_shifter_pkg;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    function automatic int shamt_w_of(input int width);
        return $clog2(width);
    endfunction

    function automatic int grp_size(input int shamt_w, input int stages);
        return (shamt_w + stages - 1) / stages;
    endfunction

    // Trailing groups can be empty when the shift width does not divide evenly.
    function automatic int grp_len(input int shamt_w, input int stages, input int k);
        int gs;
        int off;
        gs  = grp_size(shamt_w, stages);
        off = k * gs;
        if (off >= shamt_w) return 0;
        return (shamt_w - off < gs) ? (shamt_w - off) : gs;
    endfunction

endpackage

// File: rtl/pipe_shifter_stage.sv
// One pipeline slice: applies its group of shift-amount bits and registers the result.
// Latency: 1 cycle, loads only when en is high.
// Backpressure: none locally; the parent decides en from downstream occupancy.
module shift_stage
    import pipe_shifter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int GRP_OFF = 0,
    parameter int GRP_SZ  = 5
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               en,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [2:0]         in_op,
    input  logic               in_err,
    input  logic               in_msb,
    output logic [WIDTH-1:0]   out_data,
    output logic [SHAMT_W-1:0] out_shamt,
    output logic [2:0]         out_op,
    output logic               out_err,
    output logic               out_msb,
    output logic               out_zero
);

    // Masking keeps the bits in place, so amt is already weighted by the group offset.
    localparam logic [SHAMT_W-1:0] GRP_MASK = SHAMT_W'(((1 << GRP_SZ) - 1) << GRP_OFF);

    logic [SHAMT_W-1:0]   amt;
    logic [2*WIDTH-1:0]   dbl;
    logic [2*WIDTH-1:0]   sext;
    logic [WIDTH-1:0]     nxt;

    assign amt  = in_shamt & GRP_MASK;
    assign dbl  = {in_data, in_data};
    assign sext = {{WIDTH{in_msb}}, in_data};

    always_comb begin
        nxt = in_data;
        if (!in_err) begin
            case (in_op)
                OP_SLL:  nxt = in_data << amt;
                OP_SRL:  nxt = in_data >> amt;
                OP_SRA:  nxt = WIDTH'(sext >> amt);
                OP_ROL:  nxt = WIDTH'((dbl << amt) >> WIDTH);
                OP_ROR:  nxt = WIDTH'(dbl >> amt);
                default: nxt = in_data;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_data  <= '0;
            out_shamt <= '0;
            out_op    <= '0;
            out_err   <= 1'b0;
            out_msb   <= 1'b0;
            out_zero  <= 1'b0;
        end else if (en) begin
            out_data  <= nxt;
            out_shamt <= in_shamt;
            out_op    <= in_op;
            out_err   <= in_err;
            out_msb   <= in_msb;
            out_zero  <= (nxt == '0);
        end
    end

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR) with valid/ready handshakes on both sides.
// Latency: STAGES cycles from accept to out_valid with no backpressure, one op per cycle.
// Backpressure: each stage advances only into a free slot; in_ready follows the ready chain.
module pipe_shifter
    import pipe_shifter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    input  logic [shamt_w_of(WIDTH)-1:0]  in_shamt,
    input  logic [2:0]                    in_op,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic                          out_zero,
    output logic                          out_err
);

    localparam int SHAMT_W = shamt_w_of(WIDTH);
    localparam int GS      = grp_size(SHAMT_W, STAGES);

    logic [WIDTH-1:0]   d_a [0:STAGES];
    logic [SHAMT_W-1:0] s_a [0:STAGES];
    logic [2:0]         o_a [0:STAGES];
    logic               e_a [0:STAGES];
    logic               m_a [0:STAGES];

    logic [STAGES-1:0]  vld;
    logic [STAGES-1:0]  vin;
    logic [STAGES-1:0]  free;
    logic [STAGES-1:0]  ld;
    logic               zero_q;

    assign d_a[0] = in_data;
    assign s_a[0] = in_shamt;
    assign o_a[0] = in_op;
    assign e_a[0] = (in_op > OP_ROR);
    assign m_a[0] = in_data[WIDTH-1];

    // A slot can take new data if any slot at or after it is empty, or the output drains.
    always_comb begin : p_ready
        logic all_full;
        all_full = 1'b1;
        free     = '0;
        vin      = '0;
        vin[0]   = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            vin[k] = vld[k-1];
        end
        for (int k = STAGES - 1; k >= 0; k--) begin
            all_full = all_full & vld[k];
            free[k]  = !all_full || out_ready;
        end
    end

    assign ld = vin & free;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld <= '0;
        end else begin
            vld <= (vin & free) | (vld & ~free);
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic z;

        shift_stage #(
            .WIDTH   (WIDTH),
            .SHAMT_W (SHAMT_W),
            .GRP_OFF (k * GS),
            .GRP_SZ  (grp_len(SHAMT_W, STAGES, k))
        ) u_stage (
            .clk       (clk),
            .rstn      (rstn),
            .en        (ld[k]),
            .in_data   (d_a[k]),
            .in_shamt  (s_a[k]),
            .in_op     (o_a[k]),
            .in_err    (e_a[k]),
            .in_msb    (m_a[k]),
            .out_data  (d_a[k+1]),
            .out_shamt (s_a[k+1]),
            .out_op    (o_a[k+1]),
            .out_err   (e_a[k+1]),
            .out_msb   (m_a[k+1]),
            .out_zero  (z)
        );

        if (k == STAGES - 1) begin : g_last
            assign zero_q = z;
        end else begin : g_mid
            logic unused_z;
            assign unused_z = z;
        end
    end

    logic unused_tail;
    assign unused_tail = ^{s_a[STAGES], o_a[STAGES], m_a[STAGES]};

    assign in_ready  = free[0];
    assign out_valid = vld[STAGES-1];
    assign out_data  = d_a[STAGES];
    assign out_err   = e_a[STAGES];
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_pipe_shifter.sv
// Randomized and directed bench for pipe_shifter (WIDTH=32, STAGES=2) against a queue-based reference.
module tb_pipe_shifter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [2:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_zero;
    logic        out_err;

    pipe_shifter #(.WIDTH(32), .STAGES(2)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        z;
        logic        e;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        exp_next;
    int          n_chk = 0;
    int          n_err = 0;
    logic        held  = 1'b0;
    logic [33:0] held_v;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] d, input int sh);
        logic [31:0] r;
        case (op)
            3'd0:    r = d << sh;
            3'd1:    r = d >> sh;
            3'd2:    r = 32'($signed(d) >>> sh);
            3'd3:    r = (sh == 0) ? d : ((d << sh) | (d >> (32 - sh)));
            3'd4:    r = (sh == 0) ? d : ((d >> sh) | (d << (32 - sh)));
            default: r = d;
        endcase
        return '{r, (r == 32'd0), (op > 3'd4)};
    endfunction

    // Inputs are already driven; evaluate the coming edge's transfers, then advance to the next negedge.
    task automatic cycle(output logic acc);
        exp_t e;
        #1;
        if (held && out_valid)
            check("hold", {out_err, out_zero, out_data}, held_v);
        held   = rstn && out_valid && !out_ready;
        held_v = {out_err, out_zero, out_data};
        acc = rstn && in_valid && in_ready;
        if (acc) exp_q.push_back(exp_next);
        if (rstn && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("data", out_data, e.d);
                check("zero", out_zero, e.z);
                check("err",  out_err,  e.e);
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] d, input logic [4:0] sh, input exp_t e);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        in_shamt = sh;
        exp_next = e;
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] d, input logic [4:0] sh, input exp_t e);
        logic acc;
        logic done;
        done = 1'b0;
        drive(op, d, sh, e);
        for (int i = 0; i < 50 && !done; i++) begin
            cycle(acc);
            done = acc;
        end
        if (!done) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        logic acc;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) cycle(acc);
        check("drain_left", exp_q.size(), 0);
    endtask

    logic [2:0]  t_op [11] = '{3'd0, 3'd2, 3'd1, 3'd2, 3'd4, 3'd3, 3'd2, 3'd4, 3'd7, 3'd0, 3'd5};
    logic [31:0] t_d  [11] = '{32'h0000_0001, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                               32'h0000_00F1, 32'h8000_0001, 32'h8000_F000, 32'hA5A5_0001,
                               32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
    logic [4:0]  t_sh [11] = '{5'd31, 5'd4, 5'd4, 5'd31, 5'd4, 5'd1, 5'd0, 5'd0, 5'd9, 5'd3, 5'd0};
    logic [31:0] t_ed [11] = '{32'h8000_0000, 32'hF800_0000, 32'h0800_0000, 32'hFFFF_FFFF,
                               32'h1000_000F, 32'h0000_0003, 32'h8000_F000, 32'hA5A5_0001,
                               32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
    logic        t_ez [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    logic        t_ee [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        logic [2:0]  op;
        logic [31:0] d;
        logic [4:0]  sh;
        int          idx;
        logic [2:0]  b_op [6];
        logic [31:0] b_d  [6];
        logic [4:0]  b_sh [6];

        rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_shamt = '0; in_op = '0;
        exp_next = '{32'd0, 1'b0, 1'b0};
        @(negedge clk);
        cycle(acc);
        cycle(acc);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data",  out_data,  0);
        check("rst_zero",  out_zero,  0);
        check("rst_err",   out_err,   0);
        rstn = 1'b1;
        cycle(acc);
        #1;
        check("rst_in_ready", in_ready, 1);

        // Latency from an empty pipeline.
        out_ready = 1'b1;
        drive(t_op[0], t_d[0], t_sh[0], '{t_ed[0], t_ez[0], t_ee[0]});
        cycle(acc);
        check("lat_accept", acc, 1);
        in_valid = 1'b0;
        #1;
        check("lat_edge_n", out_valid, 0);
        cycle(acc);
        #1;
        check("lat_edge_n1", out_valid, 1);
        drain();

        for (int i = 1; i < 11; i++)
            send(t_op[i], t_d[i], t_sh[i], '{t_ed[i], t_ez[i], t_ee[i]});
        drain();

        // Stall the output with six ops offered: only two fit.
        for (int i = 0; i < 6; i++) begin
            b_op[i] = 3'($urandom_range(0, 4));
            b_d[i]  = $urandom;
            b_sh[i] = 5'($urandom_range(0, 31));
        end
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            drive(b_op[idx], b_d[idx], b_sh[idx], model(b_op[idx], b_d[idx], int'(b_sh[idx])));
            cycle(acc);
            if (acc) idx++;
        end
        check("bp_accepted", idx, 2);
        #1;
        check("bp_in_ready", in_ready, 0);
        out_ready = 1'b1;
        while (idx < 6) begin
            send(b_op[idx], b_d[idx], b_sh[idx], model(b_op[idx], b_d[idx], int'(b_sh[idx])));
            idx++;
        end
        drain();

        // Full pipeline with drain every cycle must accept every cycle.
        for (int i = 0; i < 10; i++) begin
            op = 3'($urandom_range(0, 7)); d = $urandom; sh = 5'($urandom_range(0, 31));
            drive(op, d, sh, model(op, d, int'(sh)));
            cycle(acc);
            check("throughput", acc, 1);
        end
        drain();

        // Reset with two ops in flight: neither may surface.
        out_ready = 1'b0;
        send(3'd0, 32'h0000_00FF, 5'd4, model(3'd0, 32'h0000_00FF, 4));
        send(3'd3, 32'hDEAD_BEEF, 5'd8, model(3'd3, 32'hDEAD_BEEF, 8));
        rstn = 1'b0;
        cycle(acc);
        exp_q.delete();
        rstn = 1'b1;
        #1;
        check("rst2_valid", out_valid, 0);
        check("rst2_data",  out_data,  0);
        check("rst2_ready", in_ready,  1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle(acc);
            #1;
            check("rst2_ghost", out_valid, 0);
        end

        // Random traffic; an offer is held until it is taken.
        acc = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (acc || !in_valid) begin
                in_valid = ($urandom_range(0, 9) < 7);
                op = 3'($urandom_range(0, 7));
                case ($urandom_range(0, 3))
                    0:       d = 32'd0;
                    1:       d = 32'h8000_0000;
                    default: d = $urandom;
                endcase
                sh = 5'($urandom_range(0, 31));
                in_op = op; in_data = d; in_shamt = sh;
                exp_next = model(op, d, int'(sh));
            end
            out_ready = ($urandom_range(0, 9) < 7);
            cycle(acc);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
